adc_capture_sequencer: RTL and testbench

//  Sequences one ADC snapshot capture into the per-channel capture BRAMs, in the adc_div2_clk domain.

---
 rtl/adc_capture_sequencer.sv | 107 ++++++++++
 tb/tb_adc_capture_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer.sv
// Sequences one ADC snapshot capture into the per-channel capture BRAMs (adc_div2_clk domain).
// Strobe -> optional holdoff -> length_i+1 writes at a shared address -> sticky per-channel done flags.
module adc_capture_sequencer #(
  parameter int NCHAN        = 8,
  parameter int ADDR_BITS    = 11,
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                    adc_div2_clk,
  input  logic                    rst,
  input  logic                    capture_i,
  input  logic [NCHAN-1:0]        chan_mask_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [ADDR_BITS-1:0]    length_i,
  output logic                    busy_o,
  output logic [NCHAN-1:0]        bram_we_o,
  output logic [ADDR_BITS-1:0]    bram_addr_o,
  output logic [NCHAN-1:0]        done_o,
  output logic                    capture_ignored_o,
  output logic [1:0]              dbg_state_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLDOFF = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE = HOLDOFF_BITS'(1);
  localparam logic [ADDR_BITS-1:0]    ADDR_ONE = ADDR_BITS'(1);

  logic [1:0]              state_q;
  logic [NCHAN-1:0]        mask_q;
  logic [ADDR_BITS-1:0]    len_q;
  logic [HOLDOFF_BITS-1:0] hold_cnt_q;

  assign dbg_state_o = state_q;

  // capture_i is a one-cycle request with no back-pressure: it is accepted only
  // in IDLE; any request seen in HOLDOFF/CAPTURE is dropped and reported one
  // cycle later on capture_ignored_o, leaving the latched M/H/L untouched.
  always_ff @(posedge adc_div2_clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      mask_q            <= '0;
      len_q             <= '0;
      hold_cnt_q        <= '0;
      busy_o            <= 1'b0;
      bram_we_o         <= '0;
      bram_addr_o       <= '0;
      done_o            <= '0;
      capture_ignored_o <= 1'b0;
    end else begin
      capture_ignored_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture_i) begin
            mask_q      <= chan_mask_i;
            len_q       <= length_i;
            done_o      <= '0;
            busy_o      <= 1'b1;
            bram_addr_o <= '0;
            if (holdoff_i != '0) begin
              hold_cnt_q <= holdoff_i;
              bram_we_o  <= '0;
              state_q    <= ST_HOLDOFF;
            end else begin
              bram_we_o <= chan_mask_i;
              state_q   <= ST_CAPTURE;
            end
          end
        end

        ST_HOLDOFF: begin
          if (capture_i) capture_ignored_o <= 1'b1;
          // Counter holds the cycles remaining including this one.
          if (hold_cnt_q == HOLD_ONE) begin
            bram_we_o   <= mask_q;
            bram_addr_o <= '0;
            state_q     <= ST_CAPTURE;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_ONE;
          end
        end

        ST_CAPTURE: begin
          if (capture_i) capture_ignored_o <= 1'b1;
          // Compare before incrementing so a full-depth run ends at the top address without wrapping.
          if (bram_addr_o == len_q) begin
            done_o      <= mask_q;
            bram_we_o   <= '0;
            bram_addr_o <= '0;
            busy_o      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            bram_addr_o <= bram_addr_o + ADDR_ONE;
          end
        end

        default: begin
          bram_we_o   <= '0;
          bram_addr_o <= '0;
          busy_o      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: cycle-exact checks of holdoff, write window,
// done flags, ignored requests, mid-run reset and back-to-back full-depth capture.
module tb_adc_capture_sequencer;

  logic        adc_div2_clk;
  logic        rst;
  logic        capture_i;
  logic [7:0]  chan_mask_i;
  logic [7:0]  holdoff_i;
  logic [10:0] length_i;
  logic        busy_o;
  logic [7:0]  bram_we_o;
  logic [10:0] bram_addr_o;
  logic [7:0]  done_o;
  logic        capture_ignored_o;
  logic [1:0]  dbg_state_o;

  int checks   = 0;
  int failures = 0;

  adc_capture_sequencer #(.NCHAN(8), .ADDR_BITS(11), .HOLDOFF_BITS(8)) dut (
    .adc_div2_clk      (adc_div2_clk),
    .rst               (rst),
    .capture_i         (capture_i),
    .chan_mask_i       (chan_mask_i),
    .holdoff_i         (holdoff_i),
    .length_i          (length_i),
    .busy_o            (busy_o),
    .bram_we_o         (bram_we_o),
    .bram_addr_o       (bram_addr_o),
    .done_o            (done_o),
    .capture_ignored_o (capture_ignored_o),
    .dbg_state_o       (dbg_state_o)
  );

  // clock / reset block
  initial adc_div2_clk = 1'b0;
  always #5 adc_div2_clk = ~adc_div2_clk;

  task automatic tick();
    @(posedge adc_div2_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic b, input logic [7:0] we,
                           input logic [10:0] addr, input logic [7:0] done, input logic ign);
    check({tag, ".busy"}, 32'(busy_o), 32'(b));
    check({tag, ".we"},   32'(bram_we_o), 32'(we));
    check({tag, ".addr"}, 32'(bram_addr_o), 32'(addr));
    check({tag, ".done"}, 32'(done_o), 32'(done));
    check({tag, ".ign"},  32'(capture_ignored_o), 32'(ign));
  endtask

  // Driver: one-cycle strobe, then scramble the config inputs to prove they were latched.
  task automatic strobe(input logic [7:0] m, input logic [7:0] h, input logic [10:0] l);
    chan_mask_i = m;
    holdoff_i   = h;
    length_i    = l;
    capture_i   = 1'b1;
    tick();
    capture_i   = 1'b0;
    chan_mask_i = 8'($urandom_range(0, 255));
    holdoff_i   = 8'($urandom_range(0, 255));
    length_i    = 11'($urandom_range(0, 2047));
  endtask

  // Called at cycle N+1 after strobe; ends on the cycle done_o first rises.
  task automatic run_check(input string tag, input logic [7:0] m, input int h, input int l);
    for (int j = 1; j <= h + l + 2; j++) begin
      logic cap;
      cap = (j >= h + 1) && (j <= h + l + 1);
      check_out($sformatf("%s[%0d]", tag, j), j <= h + l + 1, cap ? m : 8'h00,
                cap ? 11'(j - h - 1) : 11'd0, (j == h + l + 2) ? m : 8'h00, 1'b0);
      if (j < h + l + 2) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    capture_i = 1'b0;
    chan_mask_i = '0;
    holdoff_i = '0;
    length_i = '0;
    repeat (3) tick();
    check_out("reset", 1'b0, 8'h00, 11'd0, 8'h00, 1'b0);
    check("reset.state", 32'(dbg_state_o), 32'd0);
    rst = 1'b0;
    repeat (10) tick();
    check_out("idle10", 1'b0, 8'h00, 11'd0, 8'h00, 1'b0);

    // All channels, no holdoff, four writes.
    strobe(8'hFF, 8'd0, 11'd3);
    run_check("ff_h0_l3", 8'hFF, 0, 3);

    // Holdoff of 4 then a single write; done from the previous run must clear.
    strobe(8'h05, 8'd4, 11'd0);
    run_check("05_h4_l0", 8'h05, 4, 0);

    // Empty mask: full timing, no writes, done stays 0.
    strobe(8'h00, 8'd3, 11'd5);
    run_check("m0_h3_l5", 8'h00, 3, 5);

    // L=15 with holdoff 2; a second request at cycle 5 (addr 2) must be ignored.
    strobe(8'h3C, 8'd2, 11'd15);
    for (int j = 1; j <= 19; j++) begin
      logic cap;
      cap = (j >= 3) && (j <= 18);
      check_out($sformatf("ign[%0d]", j), j <= 18, cap ? 8'h3C : 8'h00,
                cap ? 11'(j - 3) : 11'd0, (j == 19) ? 8'h3C : 8'h00, j == 6);
      if (j == 5) begin
        chan_mask_i = 8'hFF;
        holdoff_i   = 8'd0;
        length_i    = 11'd1;
        capture_i   = 1'b1;
      end else begin
        capture_i = 1'b0;
      end
      if (j < 19) tick();
    end

    // Back-to-back on the done cycle into a full-depth run.
    strobe(8'h81, 8'd0, 11'd2047);
    run_check("b2b_full", 8'h81, 0, 2047);

    // Reset at addr 7 of an L=31 run.
    strobe(8'hF0, 8'd0, 11'd31);
    for (int j = 1; j <= 8; j++) begin
      check_out($sformatf("pre_rst[%0d]", j), 1'b1, 8'hF0, 11'(j - 1), 8'h00, 1'b0);
      if (j < 8) tick();
    end
    rst = 1'b1;
    tick();
    check_out("rst_mid", 1'b0, 8'h00, 11'd0, 8'h00, 1'b0);
    check("rst_mid.state", 32'(dbg_state_o), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check_out("post_rst_idle", 1'b0, 8'h00, 11'd0, 8'h00, 1'b0);
    strobe(8'h0F, 8'd1, 11'd2);
    run_check("post_rst", 8'h0F, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
